spim_bus_responder: RTL and testbench

CPU-bus responder for the NORA SPI-master register window: it decodes the 3-register block (N_SPI_CTRL, N_SPI_STAT, N_SPI_DATA at $9F63–$9F65) and serves 65C02 read/write cycles from the NORA address decoder. Behind the registers it runs an SPI mode-0 shift engine with TX and RX FIFOs that drives the SPI-flash pins (FMOSI/FMISO/FSCK/FLASHCSn). It is the peripheral-side counterpart of the CPU bus initiator: it answers register accesses and turns queued bytes into SPI traffic.

---
 rtl/spim_bus_responder_if.sv | 26 ++
 rtl/spim_bus_responder.sv | 270 +++++++++++++++++++++++++++
 tb/tb_spim_bus_responder.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spim_bus_responder_if.sv
// spim_bus_responder_if: CPU register-window strobes plus the SPI-flash pins of
// the NORA SPI-master responder, bundled so the block has a single bus port.
// Ports: regaddr/wr_en/rd_en/wdata/rdata (CPU side), spi_csn/spi_sck/spi_mosi/spi_miso (flash side).
// slave  = the responder (drives rdata and the SPI outputs).
// master = the CPU decoder plus the flash device (drive strobes, write data and spi_miso).
interface spim_bus_responder_if;
  logic [1:0] regaddr;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       spi_csn;
  logic       spi_sck;
  logic       spi_mosi;
  logic       spi_miso;

  modport slave (
    input  regaddr, wr_en, rd_en, wdata, spi_miso,
    output rdata, spi_csn, spi_sck, spi_mosi
  );

  modport master (
    output regaddr, wr_en, rd_en, wdata, spi_miso,
    input  rdata, spi_csn, spi_sck, spi_mosi
  );
endinterface

// File: rtl/spim_bus_responder.sv
// spim_bus_responder: NORA SPI-master register window (CTRL/STAT/DATA at $9F63-$9F65)
// with a mode-0 shift engine between a TX and an RX byte FIFO.
// Latency: register side effects land on the wr_en/rd_en edge; one byte = 2 + 16*2^S clk.
// Backpressure: none toward the CPU; a DATA write into a full TX FIFO is dropped and
//   flagged (STAT[3]), a received byte arriving with RX full is dropped and flagged (STAT[4]).
// Ports: clk_i, rst_i (asynchronous, active high); bus (slave modport of spim_bus_responder_if).
// Optional feature: define SPIM_LOOPBACK_EN to make CTRL[7] a loopback switch
//   (the shifter samples spi_mosi instead of spi_miso).

// spim_fifo: small synchronous byte FIFO (DEPTH must be a power of 2).
// Latency: push visible at the head one cycle later; pop removes the head on the edge.
// Backpressure: a push while full is accepted only when a pop happens in the same cycle.
module spim_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop) begin
        count_q <= count_q + CW'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end
endmodule

module spim_bus_responder #(
  parameter int TXDEPTH = 4,
  parameter int RXDEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  spim_bus_responder_if.slave  bus
);
  localparam int TXCW = $clog2(TXDEPTH + 1);
  localparam int RXCW = $clog2(RXDEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] ctrl_q, ctrl_d;
  logic [7:0] shreg_q, shreg_d;
  logic [2:0] speed_q, speed_d;
  logic [6:0] div_q, div_d;
  logic [3:0] half_q, half_d;
  logic       sck_q, sck_d;
  logic       mosi_q, mosi_d;
  logic       rx_ovf_q, rx_ovf_d;
  logic       tx_ovf_q, tx_ovf_d;

  logic            tx_full, tx_empty;
  logic [7:0]      tx_head;
  logic [TXCW-1:0] tx_count;
  logic            rx_full, rx_empty;
  logic [7:0]      rx_head;
  logic [RXCW-1:0] rx_count;

  logic       wr_ctrl, wr_stat, wr_data, rd_data;
  logic       tx_pop, tx_drop, rx_push, rx_pop, rx_drop;
  logic       miso_s;
  logic [7:0] half_len_m1;
  logic       div_end;
  logic       busy;
  logic [3:0] rx_cnt_w;
  logic [2:0] rx_cnt_sat;
  logic [7:0] stat_w;
  logic [7:0] rdata_w;

`ifdef SPIM_LOOPBACK_EN
  localparam logic [7:0] CTRL_WMASK = 8'hFF;
  assign miso_s = ctrl_q[7] ? mosi_q : bus.spi_miso;
`else
  localparam logic [7:0] CTRL_WMASK = 8'h7F;
  assign miso_s = bus.spi_miso;
`endif

  // Register decode
  assign wr_ctrl = bus.wr_en && (bus.regaddr == 2'd0);
  assign wr_stat = bus.wr_en && (bus.regaddr == 2'd1);
  assign wr_data = bus.wr_en && (bus.regaddr == 2'd2);
  assign rd_data = bus.rd_en && (bus.regaddr == 2'd2);

  // A write into a full TX FIFO survives only when the engine pops the same cycle.
  assign tx_pop  = (state_q == ST_LOAD);
  assign tx_drop = wr_data && tx_full && !tx_pop;
  assign rx_pop  = rd_data && !rx_empty;
  assign rx_push = (state_q == ST_DONE);
  assign rx_drop = rx_push && rx_full && !rx_pop;

  spim_fifo #(.DEPTH(TXDEPTH), .WIDTH(8)) u_tx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (wr_data),
    .pop_i   (tx_pop),
    .wdata_i (bus.wdata),
    .rdata_o (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count)
  );

  spim_fifo #(.DEPTH(RXDEPTH), .WIDTH(8)) u_rx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (rx_push),
    .pop_i   (rx_pop),
    .wdata_i (shreg_q),
    .rdata_o (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_count)
  );

  // Half-period length is 2^S cycles; S is the copy latched at LOAD.
  assign half_len_m1 = (8'd1 << speed_q) - 8'd1;
  assign div_end     = ({1'b0, div_q} == half_len_m1);

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    shreg_d  = shreg_q;
    speed_d  = speed_q;
    div_d    = div_q;
    half_d   = half_q;
    sck_d    = sck_q;
    mosi_d   = mosi_q;
    rx_ovf_d = rx_ovf_q;
    tx_ovf_d = tx_ovf_q;

    if (wr_ctrl) begin
      ctrl_d = bus.wdata & CTRL_WMASK;
    end
    if (wr_stat) begin
      if (bus.wdata[4]) rx_ovf_d = 1'b0;
      if (bus.wdata[3]) tx_ovf_d = 1'b0;
    end
    // A new overflow in the same cycle as a clear keeps the flag set.
    if (tx_drop) tx_ovf_d = 1'b1;
    if (rx_drop) rx_ovf_d = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (!tx_empty) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        shreg_d = tx_head;
        mosi_d  = tx_head[7];
        sck_d   = 1'b0;
        speed_d = ctrl_q[5:3];
        div_d   = '0;
        half_d  = '0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (div_end) begin
          div_d  = '0;
          sck_d  = ~sck_q;
          half_d = half_q + 4'd1;
          // Rising edge samples into the LSB; falling edge presents the next
          // bit, which after the sample shift sits in shreg[7]. The final
          // falling edge leaves mosi alone: there is no next bit.
          if (!sck_q) begin
            shreg_d = {shreg_q[6:0], miso_s};
          end else if (half_q != 4'd15) begin
            mosi_d = shreg_q[7];
          end
          if (half_q == 4'd15) state_d = ST_DONE;
        end else begin
          div_d = div_q + 7'd1;
        end
      end
      ST_DONE: begin
        state_d = tx_empty ? ST_IDLE : ST_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      ctrl_q   <= 8'h00;
      shreg_q  <= 8'h00;
      speed_q  <= 3'd0;
      div_q    <= '0;
      half_q   <= '0;
      sck_q    <= 1'b0;
      mosi_q   <= 1'b0;
      rx_ovf_q <= 1'b0;
      tx_ovf_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      shreg_q  <= shreg_d;
      speed_q  <= speed_d;
      div_q    <= div_d;
      half_q   <= half_d;
      sck_q    <= sck_d;
      mosi_q   <= mosi_d;
      rx_ovf_q <= rx_ovf_d;
      tx_ovf_q <= tx_ovf_d;
    end
  end

  // Status and read mux
  assign busy       = (state_q != ST_IDLE) || (tx_count != '0);
  assign rx_cnt_w   = 4'(rx_count);
  assign rx_cnt_sat = (rx_cnt_w > 4'd7) ? 3'd7 : rx_cnt_w[2:0];
  assign stat_w     = {busy, rx_empty, tx_full, rx_ovf_q, tx_ovf_q, rx_cnt_sat};

  always_comb begin
    rdata_w = 8'h00;
    case (bus.regaddr)
      2'd0:    rdata_w = ctrl_q;
      2'd1:    rdata_w = stat_w;
      2'd2:    rdata_w = rx_empty ? 8'h00 : rx_head;
      default: rdata_w = 8'h00;
    endcase
  end

  assign bus.rdata    = rdata_w;
  assign bus.spi_csn  = ~ctrl_q[0];
  assign bus.spi_sck  = sck_q;
  assign bus.spi_mosi = mosi_q;
endmodule

// File: tb/tb_spim_bus_responder.sv
// tb_spim_bus_responder: self-checking bench for spim_bus_responder.
// Expected RX bytes are pushed to a scoreboard queue as DATA is written and
// compared as the CPU reads them back; miso is driven as ~mosi by default.
module tb_spim_bus_responder;
  logic clk_i    = 1'b0;
  logic rst_i    = 1'b1;
  logic miso_inv = 1'b1;
  int   vec      = 0;
  int   errs     = 0;
  logic [7:0] exp_q[$];

  spim_bus_responder_if bif();

  spim_bus_responder #(.TXDEPTH(4), .RXDEPTH(4)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bif)
  );

  assign bif.spi_miso = bif.spi_mosi ^ miso_inv;

  always #5 clk_i = ~clk_i;

`ifdef SPIM_LOOPBACK_EN
  localparam logic [7:0] CTRL_ALL_ONES = 8'hFF;
`else
  localparam logic [7:0] CTRL_ALL_ONES = 8'h7F;
`endif

  // ---------------- bus primitives (no checking) ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    bif.regaddr = a;
    bif.wdata   = d;
    bif.wr_en   = 1'b1;
    @(posedge clk_i);
    #1;
    bif.wr_en   = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    bif.regaddr = a;
    bif.rd_en   = 1'b1;
    #1;
    d = bif.rdata;
    @(posedge clk_i);
    #1;
    bif.rd_en   = 1'b0;
  endtask

  task automatic peek(input logic [1:0] a, output logic [7:0] d);
    bif.regaddr = a;
    #1;
    d = bif.rdata;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    logic [7:0] s;
    int n;
    n = 0;
    peek(2'd1, s);
    while (s[7] && n < budget) begin
      tick(1);
      peek(2'd1, s);
      n++;
    end
    vec++;
    if (s[7] !== 1'b0) begin
      errs++;
      $display("FAIL %s: BUSY=%0b after %0d cycles, want 0", tag, s[7], budget);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [7:0] d;
    rst_i = 1'b1;
    tick(2);
    vec++;
    if (bif.spi_csn !== 1'b1) begin errs++; $display("FAIL rst_csn: got %b want 1", bif.spi_csn); end
    vec++;
    if (bif.spi_sck !== 1'b0) begin errs++; $display("FAIL rst_sck: got %b want 0", bif.spi_sck); end
    vec++;
    if (bif.spi_mosi !== 1'b0) begin errs++; $display("FAIL rst_mosi: got %b want 0", bif.spi_mosi); end
    peek(2'd1, d);
    vec++;
    if (d !== 8'h40) begin errs++; $display("FAIL rst_stat: got %h want 40", d); end
    rst_i = 1'b0;
    tick(1);
    peek(2'd1, d);
    vec++;
    if (d !== 8'h40) begin errs++; $display("FAIL post_rst_stat: got %h want 40", d); end
    peek(2'd0, d);
    vec++;
    if (d !== 8'h00) begin errs++; $display("FAIL post_rst_ctrl: got %h want 00", d); end
    bus_read(2'd2, d);
    vec++;
    if (d !== 8'h00) begin errs++; $display("FAIL empty_data: got %h want 00", d); end
  endtask

  task automatic test_ctrl_speed();
    logic [7:0] d;
    int n, hi, lo;
    bus_write(2'd0, 8'h21);
    peek(2'd0, d);
    vec++;
    if (d !== 8'h21) begin errs++; $display("FAIL ctrl_rb: got %h want 21", d); end
    vec++;
    if (bif.spi_csn !== 1'b0) begin errs++; $display("FAIL ctrl_csn: got %b want 0", bif.spi_csn); end
    bus_write(2'd3, 8'hFF);
    peek(2'd3, d);
    vec++;
    if (d !== 8'h00) begin errs++; $display("FAIL rsvd_rd: got %h want 00", d); end
    peek(2'd0, d);
    vec++;
    if (d !== 8'h21) begin errs++; $display("FAIL rsvd_wr_ctrl: got %h want 21", d); end
    bus_write(2'd0, 8'hFF);
    peek(2'd0, d);
    vec++;
    if (d !== CTRL_ALL_ONES) begin errs++; $display("FAIL ctrl_mask: got %h want %h", d, CTRL_ALL_ONES); end
    bus_write(2'd0, 8'h21);

    // S=4: both sck phases inside the byte last 16 clk
    bus_write(2'd2, 8'hA5);
    exp_q.push_back(8'h5A);
    n = 0;
    while (bif.spi_sck !== 1'b1 && n < 100) begin tick(1); n++; end
    hi = 0;
    while (bif.spi_sck === 1'b1 && hi < 100) begin hi++; tick(1); end
    lo = 0;
    while (bif.spi_sck === 1'b0 && lo < 100) begin lo++; tick(1); end
    vec++;
    if (hi != 16) begin errs++; $display("FAIL sck_high: got %0d clk want 16", hi); end
    vec++;
    if (lo != 16) begin errs++; $display("FAIL sck_low: got %0d clk want 16", lo); end
    wait_idle(600, "ctrl_idle");
    bus_read(2'd2, d);
    begin
      logic [7:0] e;
      e = exp_q.pop_front();
      vec++;
      if (d !== e) begin errs++; $display("FAIL ctrl_rx: got %h want %h", d, e); end
    end
  endtask

  task automatic test_busy_timing();
    logic [7:0] d, e;
    int n;
    bus_write(2'd0, 8'h01);
    bus_write(2'd2, 8'h81);
    exp_q.push_back(8'h7E);
    // BUSY seen from the write edge through the DONE cycle: 1 + 18 samples
    n = 0;
    peek(2'd1, d);
    while (d[7] && n < 200) begin n++; tick(1); peek(2'd1, d); end
    vec++;
    if (n != 19) begin errs++; $display("FAIL busy_len: got %0d want 19", n); end
    vec++;
    if (d !== 8'h01) begin errs++; $display("FAIL busy_fall_stat: got %h want 01", d); end
    bus_read(2'd2, d);
    e = exp_q.pop_front();
    vec++;
    if (d !== e) begin errs++; $display("FAIL busy_rx: got %h want %h", d, e); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d, e;
    logic [7:0] tx [3];
    int n;
    tx[0] = 8'h03; tx[1] = 8'h12; tx[2] = 8'h34;
    bus_write(2'd0, 8'h01);
    for (int i = 0; i < 3; i++) begin
      bus_write(2'd2, tx[i]);
      exp_q.push_back(~tx[i]);
    end
    // three 18-cycle bytes chained DONE->LOAD with no idle cycle
    n = 0;
    peek(2'd1, d);
    while (d[7] && n < 500) begin n++; tick(1); peek(2'd1, d); end
    vec++;
    if (n != 53) begin errs++; $display("FAIL b2b_busy_len: got %0d want 53", n); end
    for (int i = 0; i < 3; i++) begin
      bus_read(2'd2, d);
      e = exp_q.pop_front();
      vec++;
      if (d !== e) begin errs++; $display("FAIL b2b_rx%0d: got %h want %h", i, d, e); end
    end
    bus_read(2'd2, d);
    vec++;
    if (d !== 8'h00) begin errs++; $display("FAIL b2b_empty: got %h want 00", d); end
    peek(2'd1, d);
    vec++;
    if (d[6] !== 1'b1) begin errs++; $display("FAIL b2b_rxempty: got %b want 1", d[6]); end
  endtask

  task automatic test_rx_overflow();
    logic [7:0] d, e;
    bus_write(2'd0, 8'h01);
    for (int i = 0; i < 5; i++) begin
      bus_write(2'd2, 8'(8'h60 + i));
      if (i < 4) exp_q.push_back(~8'(8'h60 + i));
    end
    wait_idle(500, "rxovf_idle");
    peek(2'd1, d);
    vec++;
    if (d !== 8'h14) begin errs++; $display("FAIL rxovf_stat: got %h want 14", d); end
    bus_write(2'd1, 8'h10);
    peek(2'd1, d);
    vec++;
    if (d !== 8'h04) begin errs++; $display("FAIL rxovf_clr: got %h want 04", d); end
    for (int i = 0; i < 4; i++) begin
      bus_read(2'd2, d);
      e = exp_q.pop_front();
      vec++;
      if (d !== e) begin errs++; $display("FAIL rxovf_rx%0d: got %h want %h", i, d, e); end
    end
    peek(2'd1, d);
    vec++;
    if (d !== 8'h40) begin errs++; $display("FAIL rxovf_end: got %h want 40", d); end
  endtask

  task automatic test_tx_overflow();
    logic [7:0] d, e;
    int n;
    bus_write(2'd0, 8'h39);
    bus_write(2'd2, 8'h11);
    exp_q.push_back(8'hEE);
    tick(5);
    // engine holds the first byte; 4 fill TX, the 5th is dropped
    for (int i = 0; i < 5; i++) begin
      bus_write(2'd2, 8'(8'h22 + 8'h11 * i));
      if (i < 4) exp_q.push_back(~8'(8'h22 + 8'h11 * i));
    end
    peek(2'd1, d);
    vec++;
    if (d !== 8'hE8) begin errs++; $display("FAIL txovf_stat: got %h want e8", d); end
    // new speed applies from the next LOAD; the current byte stays at S=7
    bus_write(2'd0, 8'h01);
    n = 0;
    peek(2'd1, d);
    while (d[6] && n < 3000) begin n++; tick(1); peek(2'd1, d); end
    vec++;
    if (d[6] !== 1'b0) begin errs++; $display("FAIL txovf_first: rx_empty=%b want 0", d[6]); end
    bus_read(2'd2, d);
    e = exp_q.pop_front();
    vec++;
    if (d !== e) begin errs++; $display("FAIL txovf_rx0: got %h want %h", d, e); end
    wait_idle(500, "txovf_idle");
    for (int i = 1; i < 5; i++) begin
      bus_read(2'd2, d);
      e = exp_q.pop_front();
      vec++;
      if (d !== e) begin errs++; $display("FAIL txovf_rx%0d: got %h want %h", i, d, e); end
    end
    peek(2'd1, d);
    vec++;
    if (d !== 8'h48) begin errs++; $display("FAIL txovf_sticky: got %h want 48", d); end
    bus_write(2'd1, 8'h08);
    peek(2'd1, d);
    vec++;
    if (d !== 8'h40) begin errs++; $display("FAIL txovf_clr: got %h want 40", d); end
  endtask

  task automatic test_reset_mid_shift();
    logic [7:0] d, e;
    int n;
    bus_write(2'd0, 8'h11);
    bus_write(2'd2, 8'hF0);
    n = 0;
    while (bif.spi_sck !== 1'b1 && n < 100) begin tick(1); n++; end
    vec++;
    if (bif.spi_sck !== 1'b1) begin errs++; $display("FAIL mid_sck_rise: got %b want 1", bif.spi_sck); end
    rst_i = 1'b1;
    #1;
    vec++;
    if (bif.spi_sck !== 1'b0) begin errs++; $display("FAIL mid_rst_sck: got %b want 0", bif.spi_sck); end
    vec++;
    if (bif.spi_csn !== 1'b1) begin errs++; $display("FAIL mid_rst_csn: got %b want 1", bif.spi_csn); end
    tick(1);
    peek(2'd1, d);
    vec++;
    if (d !== 8'h40) begin errs++; $display("FAIL mid_rst_stat: got %h want 40", d); end
    rst_i = 1'b0;
    exp_q.delete();
    tick(1);
    bus_write(2'd0, 8'h01);
    bus_write(2'd2, 8'h5C);
    exp_q.push_back(8'hA3);
    wait_idle(200, "post_rst_idle");
    bus_read(2'd2, d);
    e = exp_q.pop_front();
    vec++;
    if (d !== e) begin errs++; $display("FAIL post_rst_rx: got %h want %h", d, e); end
  endtask

  initial begin
    bif.regaddr = 2'd0;
    bif.wr_en   = 1'b0;
    bif.rd_en   = 1'b0;
    bif.wdata   = 8'h00;
    test_reset();
    test_ctrl_speed();
    test_busy_timing();
    test_back_to_back();
    test_rx_overflow();
    test_tx_overflow();
    test_reset_mid_shift();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
